// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - MDU issue/latency sequencer with D-stage interlock
// Define MDU_MACC_EN to make madd/maddu/msub/msubu (9-12) start-class ops.
module mdu_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] E_MDUop,
   input  logic       E_valid,
   input  logic [3:0] D_MDUop,
   output logic       start,
   output logic [3:0] start_op,
   output logic       busy,
   output logic       commit,
   output logic       stall_D,
   output logic [3:0] remaining
);

   localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_remaining;
   logic [3:0] w_remaining_nxt;
   logic       w_e_start_class;
   logic       w_e_is_div;
   logic       w_d_mdu;

   always_comb begin
      w_e_is_div = (E_MDUop == 4'd3) || (E_MDUop == 4'd4);
`ifdef MDU_MACC_EN
      w_e_start_class = (E_MDUop >= 4'd1) && (E_MDUop <= 4'd4) ||
                        (E_MDUop >= 4'd9) && (E_MDUop <= 4'd12);
      w_d_mdu         = (D_MDUop >= 4'd1) && (D_MDUop <= 4'd12);
`else
      w_e_start_class = (E_MDUop >= 4'd1) && (E_MDUop <= 4'd4);
      w_d_mdu         = (D_MDUop >= 4'd1) && (D_MDUop <= 4'd8);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_remaining <= 4'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      start           = 1'b0;
      start_op        = 4'd0;
      case (r_state)
         IDLE: begin
            if (E_valid && w_e_start_class) begin
               start           = 1'b1;
               start_op        = E_MDUop;
               w_state_nxt     = RUN;
               w_remaining_nxt = w_e_is_div ? LP_DIV_CNT : LP_MULT_CNT;
            end
         end
         RUN: begin
            // E-stage opcodes are ignored here; the D interlock keeps them out.
            if (r_remaining == 4'd1) begin
               w_state_nxt     = IDLE;
               w_remaining_nxt = 4'd0;
            end else begin
               w_remaining_nxt = r_remaining - 4'd1;
            end
         end
         default: begin
            w_state_nxt     = IDLE;
            w_remaining_nxt = 4'd0;
         end
      endcase
   end

   // A reset landing on the final count must not leak a commit into HI/LO.
   assign busy      = (r_state == RUN);
   assign commit    = (r_state == RUN) && (r_remaining == 4'd1) && !reset;
   assign stall_D   = w_d_mdu && (busy || start);
   assign remaining = r_remaining;

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Sequencing controller for the multi-cycle multiply/divide unit in the five-stage pipeline. It sits beside the E-stage MDU. It decodes the MDU opcode of the instruction in E, issues a one-cycle start to the datapath, and counts the operation latency. It signals the HI/LO commit cycle and produces the D-stage stall that keeps any MDU-class instruction out of E while the unit is occupied.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (and multiply-accumulate ops); must be ≥1
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥1
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- E_MDUop  in  4  opcode of E-stage instruction. Encoding:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu
  - 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
  - 9 madd, 10 maddu, 11 msub, 12 msubu
- E_valid  in  1  E-stage instruction is real (0 = bubble/flushed)
- D_MDUop  in  4  opcode of D-stage instruction, same encoding
- start  out  1  combinational; datapath latches operands and computes this cycle
- start_op  out  4  opcode accompanying start; 0 when start=0
- busy  out  1  registered; operation in flight
- commit  out  1  registered; datapath copies temp results into HI/LO this cycle
- stall_D  out  1  combinational; freeze PC/F/D and insert bubble into E
- remaining  out  4  current countdown value, for debug/trace

## Operation
- States: IDLE, RUN. `busy = (state==RUN)`.
- Start-class ops: 1–4 always; 9–12 only with `MDU_MACC_EN`.
- IDLE: if `E_valid` and `E_MDUop` is start-class, then:
  - `start=1`, `start_op=E_MDUop`
  - next state RUN, `remaining <= MULT_CYCLES` (ops 1, 2, 9–12) or `DIV_CYCLES` (ops 3, 4).
- IDLE, all other ops: no state change, `start=0`. Ops 5–8 are serviced by the datapath directly.
- RUN: `remaining` decrements each cycle.
  - `commit = (state==RUN && remaining==1)`.
  - On that cycle the next state is IDLE and `remaining` becomes 0.
- `start` is never asserted while busy. Any E-stage opcode during RUN is ignored; stall_D guarantees none arrives.
- `stall_D = (D_MDUop!=0) && (busy || start)`. This covers all ops 1–12, so mfhi/mflo never read stale HI/LO and mthi/mtlo never race the commit.
- Opcodes 13–15, and 9–12 without the macro, are treated as 0: no start and no stall contribution from D.
- Divide-by-zero: no special case; full DIV_CYCLES latency. The datapath result is undefined per ISA.

## Timing
- Reset values: state IDLE, `remaining`=0, `busy`=0, `commit`=0. `start`, `start_op` and `stall_D` follow inputs combinationally and are 0 while inputs are 0.
- Issue at cycle T (start=1). busy=1 for cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
- commit=1 at T+N only.
- busy=0 at T+N+1, where a new start may occur.
- HI/LO are readable by an mfhi entering E at T+N+1.
- Back-to-back: the minimum issue spacing is N+1 cycles.
- D stall is asserted in cycles T … T+N whenever D holds an MDU op.
- Reset asserted mid-RUN:
  - next cycle IDLE, busy=0
  - the pending commit is dropped
  - no commit pulse is emitted on the reset cycle.
- E_valid=0 with a start-class opcode: no issue.

## Configuration
- `MDU_MACC_EN` defined: ops 9–12 are start-class with MULT_CYCLES latency and contribute to stall_D.
- Undefined: ops 9–12 are ignored exactly like opcode 0. No start, no busy, no stall.

## Test plan
- Reset, then mult (E_MDUop=1, E_valid=1) at cycle 0:
  - start=1, start_op=1 at cycle 0
  - busy=1 cycles 1–5, remaining 5→1
  - commit=1 only at cycle 5; busy=0 at cycle 6.
- div at cycle 0 with D_MDUop=6 (mflo) held in D:
  - stall_D=1 cycles 0–10, commit at cycle 10
  - stall_D=0 at cycle 11.
- mult at 0, followed by an unrelated ALU op in D (D_MDUop=0): stall_D stays 0 throughout; busy still 1 cycles 1–5.
- divu issued, reset pulsed at cycle 4: busy=0 from cycle 5, commit never asserted, remaining=0.
- E_MDUop=9 (madd) with E_valid=1:
  - with MDU_MACC_EN: 5-cycle busy, commit at 5
  - without it: start=0, busy stays 0.
- E_MDUop=3 with E_valid=0: no start, busy 0. mthi (7) in E while idle: start=0, no stall.
